// File: rtl/stimulus_scheduler.sv
// stimulus_scheduler
//
// Round-robin arbiter and sequencer. It turns each accepted host stimulus
// request into a two-beat injection on the single external stimulus port of
// the NoC system top. The first beat writes the input current. The second
// beat writes 1 to register offset 6 of the neuron's 8-word window, which
// triggers the neuron. A programmable hold-off follows each injection.
// Requests that address a node or neuron outside the mesh are accepted, then
// dropped, and flagged on req_err_o.
//
// Ports
//   clk_i                single clock, rising edge
//   rst_i                synchronous, active-high reset
//   sched_enable_i       when low, no new grants (an in-flight injection completes)
//   req_valid_i          per-requester request
//   req_ready_o          one-hot accept pulse (combinational, IDLE only)
//   req_node_x_i         packed target columns, requester i at [4i+3:4i]
//   req_node_y_i         packed target rows
//   req_neuron_id_i      packed target neurons
//   req_current_i        packed IEEE-754 currents, requester i at [32i+31:32i]
//   ext_node_select_o    {node_y, node_x} of the current beat
//   ext_neuron_id_o      neuron / register address of the current beat
//   ext_input_current_o  data word of the current beat
//   ext_input_valid_o    beat strobe
//   busy_o               high whenever the FSM is not IDLE
//   req_err_o            one-cycle pulse after an out-of-range request is accepted
//   inject_count_o       completed injections, wraps at 16 bits

module stimulus_scheduler #(
  parameter int NUM_REQ              = 4,
  parameter int MESH_SIZE_X          = 2,
  parameter int MESH_SIZE_Y          = 2,
  parameter int NUM_NEURONS_PER_BANK = 4,
  parameter int HOLDOFF_CYCLES       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sched_enable_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*4-1:0]  req_node_x_i,
  input  logic [NUM_REQ*4-1:0]  req_node_y_i,
  input  logic [NUM_REQ*4-1:0]  req_neuron_id_i,
  input  logic [NUM_REQ*32-1:0] req_current_i,
  output logic [7:0]            ext_node_select_o,
  output logic [7:0]            ext_neuron_id_o,
  output logic [31:0]           ext_input_current_o,
  output logic                  ext_input_valid_o,
  output logic                  busy_o,
  output logic                  req_err_o,
  output logic [15:0]           inject_count_o
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CURRENT,
    TRIGGER,
    HOLDOFF
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [PTR_W-1:0]    rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [3:0]          neuron_q;
  logic [7:0]          ext_sel_q;
  logic [7:0]          ext_id_q;
  logic [31:0]         ext_cur_q;
  logic                ext_valid_q;
  logic                req_err_q;
  logic [15:0]         inject_count_q;

  // Unpacked views of the packed requester buses
  logic [3:0]  node_x_arr  [NUM_REQ];
  logic [3:0]  node_y_arr  [NUM_REQ];
  logic [3:0]  neuron_arr  [NUM_REQ];
  logic [31:0] current_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign node_x_arr[i]  = req_node_x_i[4*i +: 4];
    assign node_y_arr[i]  = req_node_y_i[4*i +: 4];
    assign neuron_arr[i]  = req_neuron_id_i[4*i +: 4];
    assign current_arr[i] = req_current_i[32*i +: 32];
  end

  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand_idx;
  int               cand_int;
  logic             grant_en;
  logic [3:0]       sel_x;
  logic [3:0]       sel_y;
  logic [3:0]       sel_n;
  logic [31:0]      sel_cur;
  logic             in_range;

  // Round-robin search: the first valid requester at or after rr_ptr_q,
  // wrapping modulo NUM_REQ, so the search also works when NUM_REQ is not a
  // power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_int    = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_int = (int'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = cand_int[PTR_W-1:0];
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Reset masks the accept so that no ready pulse occurs in the reset cycle.
  assign grant_en = (state_q == IDLE) && sched_enable_i && grant_found && !rst_i;

  assign sel_x   = node_x_arr[grant_idx];
  assign sel_y   = node_y_arr[grant_idx];
  assign sel_n   = neuron_arr[grant_idx];
  assign sel_cur = current_arr[grant_idx];

  assign in_range = (int'(sel_x) < MESH_SIZE_X) &&
                    (int'(sel_y) < MESH_SIZE_Y) &&
                    (int'(sel_n) < NUM_NEURONS_PER_BANK);

  assign rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (grant_en) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // The output registers are loaded one edge ahead of the state they
  // represent. The grant edge already loads the CURRENT beat, and the
  // CURRENT cycle loads the TRIGGER beat. Each beat therefore appears in the
  // cycle that state_q names it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      hold_q         <= '0;
      neuron_q       <= '0;
      ext_sel_q      <= '0;
      ext_id_q       <= '0;
      ext_cur_q      <= '0;
      ext_valid_q    <= 1'b0;
      req_err_q      <= 1'b0;
      inject_count_q <= '0;
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            rr_ptr_q <= rr_ptr_d;
            if (in_range) begin
              neuron_q    <= sel_n;
              ext_sel_q   <= {sel_y, sel_x};
              ext_id_q    <= {4'h0, sel_n};
              ext_cur_q   <= sel_cur;
              ext_valid_q <= 1'b1;
              state_q     <= CURRENT;
            end else begin
              req_err_q <= 1'b1;
            end
          end
        end
        CURRENT: begin
          // Trigger register of the neuron's window: neuron*8 + 6
          ext_id_q  <= {1'b0, neuron_q, 3'b110};
          ext_cur_q <= 32'h0000_0001;
          state_q   <= TRIGGER;
        end
        TRIGGER: begin
          ext_valid_q    <= 1'b0;
          inject_count_q <= inject_count_q + 16'd1;
          hold_q         <= HOLD_LOAD;
          state_q        <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hold_q == '0) begin
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ext_node_select_o   = ext_sel_q;
  assign ext_neuron_id_o     = ext_id_q;
  assign ext_input_current_o = ext_cur_q;
  assign ext_input_valid_o   = ext_valid_q;
  assign busy_o              = (state_q != IDLE);
  assign req_err_o           = req_err_q;
  assign inject_count_o      = inject_count_q;

endmodule

// File: tb/tb_stimulus_scheduler.sv
// tb_stimulus_scheduler
//
// Directed bench for stimulus_scheduler with the default parameters
// (4 requesters, 2x2 mesh, 4 neurons per bank, hold-off of 4 cycles).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are written out by hand for each step.

module tb_stimulus_scheduler;

  logic        clk;
  logic        rst;
  logic        schedEnable;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [15:0] reqNodeX;
  logic [15:0] reqNodeY;
  logic [15:0] reqNeuronId;
  logic [127:0] reqCurrent;
  logic [7:0]  extNodeSelect;
  logic [7:0]  extNeuronId;
  logic [31:0] extInputCurrent;
  logic        extInputValid;
  logic        busy;
  logic        reqErr;
  logic [15:0] injectCount;

  int compared;
  int mismatched;

  stimulus_scheduler #(
    .NUM_REQ(4),
    .MESH_SIZE_X(2),
    .MESH_SIZE_Y(2),
    .NUM_NEURONS_PER_BANK(4),
    .HOLDOFF_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sched_enable_i(schedEnable),
    .req_valid_i(reqValid),
    .req_ready_o(reqReady),
    .req_node_x_i(reqNodeX),
    .req_node_y_i(reqNodeY),
    .req_neuron_id_i(reqNeuronId),
    .req_current_i(reqCurrent),
    .ext_node_select_o(extNodeSelect),
    .ext_neuron_id_o(extNeuronId),
    .ext_input_current_o(extInputCurrent),
    .ext_input_valid_o(extInputValid),
    .busy_o(busy),
    .req_err_o(reqErr),
    .inject_count_o(injectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int r, input logic v, input logic [3:0] x,
                               input logic [3:0] y, input logic [3:0] n,
                               input logic [31:0] cur);
    reqValid[r]             = v;
    reqNodeX[4*r +: 4]      = x;
    reqNodeY[4*r +: 4]      = y;
    reqNeuronId[4*r +: 4]   = n;
    reqCurrent[32*r +: 32]  = cur;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int g;
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    schedEnable = 1'b1;
    reqValid    = '0;
    reqNodeX    = '0;
    reqNodeY    = '0;
    reqNeuronId = '0;
    reqCurrent  = '0;

    step();
    step();
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(extInputValid), 32'h0);
    checkOutput("rst_sel", 32'(extNodeSelect), 32'h0);
    checkOutput("rst_id", 32'(extNeuronId), 32'h0);
    checkOutput("rst_cur", extInputCurrent, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_err", 32'(reqErr), 32'h0);
    checkOutput("rst_count", 32'(injectCount), 32'h0);
    checkOutput("rst_ready", 32'(reqReady), 32'h0);
    rst = 1'b0;

    $display("[TB] single request from requester 0");
    applyStimulus(0, 1'b1, 4'd0, 4'd0, 4'd0, 32'h42C8_0000);
    #1;
    checkOutput("t1_ready", 32'(reqReady), 32'h1);
    checkOutput("t1_busy_idle", 32'(busy), 32'h0);
    step();
    applyStimulus(0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    checkOutput("t1_cur_valid", 32'(extInputValid), 32'h1);
    checkOutput("t1_cur_sel", 32'(extNodeSelect), 32'h00);
    checkOutput("t1_cur_id", 32'(extNeuronId), 32'h00);
    checkOutput("t1_cur_data", extInputCurrent, 32'h42C8_0000);
    checkOutput("t1_cur_busy", 32'(busy), 32'h1);
    checkOutput("t1_cur_ready", 32'(reqReady), 32'h0);
    step();
    checkOutput("t1_trg_valid", 32'(extInputValid), 32'h1);
    checkOutput("t1_trg_sel", 32'(extNodeSelect), 32'h00);
    checkOutput("t1_trg_id", 32'(extNeuronId), 32'h06);
    checkOutput("t1_trg_data", extInputCurrent, 32'h1);
    step();
    checkOutput("t1_hold_valid", 32'(extInputValid), 32'h0);
    checkOutput("t1_count", 32'(injectCount), 32'h1);
    checkOutput("t1_hold_id", 32'(extNeuronId), 32'h06);
    step();
    step();
    step();
    checkOutput("t1_busy_t6", 32'(busy), 32'h1);
    step();
    checkOutput("t1_busy_t7", 32'(busy), 32'h0);

    $display("[TB] single request from requester 1");
    applyStimulus(1, 1'b1, 4'd1, 4'd0, 4'd1, 32'h4396_0000);
    #1;
    checkOutput("t2_ready", 32'(reqReady), 32'h2);
    step();
    applyStimulus(1, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    checkOutput("t2_cur_valid", 32'(extInputValid), 32'h1);
    checkOutput("t2_cur_sel", 32'(extNodeSelect), 32'h01);
    checkOutput("t2_cur_id", 32'(extNeuronId), 32'h01);
    checkOutput("t2_cur_data", extInputCurrent, 32'h4396_0000);
    step();
    checkOutput("t2_trg_sel", 32'(extNodeSelect), 32'h01);
    checkOutput("t2_trg_id", 32'(extNeuronId), 32'h0E);
    checkOutput("t2_trg_data", extInputCurrent, 32'h1);
    step();
    checkOutput("t2_count", 32'(injectCount), 32'h2);
    repeat (4) step();
    checkOutput("t2_idle", 32'(busy), 32'h0);

    $display("[TB] all requesters valid, round-robin");
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t3_count_cleared", 32'(injectCount), 32'h0);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(r, 1'b1, 4'(r % 2), 4'(r / 2), 4'(r), 32'h1000_0000 + 32'(r));
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      checkOutput("t3_ready", 32'(reqReady), 32'h1 << g);
      step();
      checkOutput("t3_cur_valid", 32'(extInputValid), 32'h1);
      checkOutput("t3_cur_sel", 32'(extNodeSelect), 32'((g / 2) * 16 + (g % 2)));
      checkOutput("t3_cur_id", 32'(extNeuronId), 32'(g));
      checkOutput("t3_cur_data", extInputCurrent, 32'h1000_0000 + 32'(g));
      checkOutput("t3_cur_ready", 32'(reqReady), 32'h0);
      step();
      checkOutput("t3_trg_id", 32'(extNeuronId), 32'(g * 8 + 6));
      checkOutput("t3_trg_ready", 32'(reqReady), 32'h0);
      for (int h = 0; h < 4; h++) begin
        step();
        checkOutput("t3_hold_valid", 32'(extInputValid), 32'h0);
        checkOutput("t3_hold_ready", 32'(reqReady), 32'h0);
      end
      step();
    end
    reqValid = '0;
    #1;
    checkOutput("t3_ready_off", 32'(reqReady), 32'h0);
    checkOutput("t3_count", 32'(injectCount), 32'h5);
    checkOutput("t3_idle", 32'(busy), 32'h0);

    $display("[TB] out-of-range request from requester 2");
    applyStimulus(2, 1'b1, 4'd2, 4'd0, 4'd0, 32'h4500_0000);
    applyStimulus(3, 1'b1, 4'd1, 4'd1, 4'd3, 32'h4400_0000);
    #1;
    checkOutput("t4_ready_bad", 32'(reqReady), 32'h4);
    step();
    applyStimulus(2, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    #1;
    checkOutput("t4_ready_next", 32'(reqReady), 32'h8);
    checkOutput("t4_err", 32'(reqErr), 32'h1);
    checkOutput("t4_no_valid", 32'(extInputValid), 32'h0);
    checkOutput("t4_not_busy", 32'(busy), 32'h0);
    checkOutput("t4_id_hold", 32'(extNeuronId), 32'h06);
    step();
    applyStimulus(3, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    checkOutput("t4_cur_valid", 32'(extInputValid), 32'h1);
    checkOutput("t4_cur_sel", 32'(extNodeSelect), 32'h11);
    checkOutput("t4_cur_id", 32'(extNeuronId), 32'h03);
    checkOutput("t4_cur_data", extInputCurrent, 32'h4400_0000);
    checkOutput("t4_err_pulse", 32'(reqErr), 32'h0);
    step();
    checkOutput("t4_trg_id", 32'(extNeuronId), 32'h1E);
    step();
    checkOutput("t4_count", 32'(injectCount), 32'h6);
    repeat (4) step();

    $display("[TB] enable dropped during CURRENT");
    applyStimulus(1, 1'b1, 4'd0, 4'd1, 4'd2, 32'h3F80_0000);
    #1;
    checkOutput("t5_ready", 32'(reqReady), 32'h2);
    step();
    schedEnable = 1'b0;
    applyStimulus(1, 1'b0, 4'd1, 4'd1, 4'd2, 32'hDEAD_BEEF);
    applyStimulus(2, 1'b1, 4'd1, 4'd1, 4'd0, 32'h4000_0000);
    checkOutput("t5_cur_valid", 32'(extInputValid), 32'h1);
    checkOutput("t5_cur_sel", 32'(extNodeSelect), 32'h10);
    checkOutput("t5_cur_id", 32'(extNeuronId), 32'h02);
    checkOutput("t5_cur_data", extInputCurrent, 32'h3F80_0000);
    step();
    checkOutput("t5_trg_valid", 32'(extInputValid), 32'h1);
    checkOutput("t5_trg_sel", 32'(extNodeSelect), 32'h10);
    checkOutput("t5_trg_id", 32'(extNeuronId), 32'h16);
    step();
    checkOutput("t5_count", 32'(injectCount), 32'h7);
    repeat (4) step();
    #1;
    checkOutput("t5_blocked", 32'(reqReady), 32'h0);
    checkOutput("t5_blocked_busy", 32'(busy), 32'h0);
    step();
    checkOutput("t5_blocked2", 32'(reqReady), 32'h0);
    checkOutput("t5_no_valid", 32'(extInputValid), 32'h0);
    schedEnable = 1'b1;
    #1;
    checkOutput("t5_reenable", 32'(reqReady), 32'h4);
    step();
    applyStimulus(2, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    checkOutput("t5b_cur_sel", 32'(extNodeSelect), 32'h11);
    checkOutput("t5b_cur_id", 32'(extNeuronId), 32'h00);
    checkOutput("t5b_cur_data", extInputCurrent, 32'h4000_0000);
    step();
    checkOutput("t5b_trg_id", 32'(extNeuronId), 32'h06);
    step();
    checkOutput("t5b_count", 32'(injectCount), 32'h8);
    repeat (4) step();

    $display("[TB] reset during CURRENT");
    applyStimulus(0, 1'b1, 4'd1, 4'd0, 4'd1, 32'h4120_0000);
    applyStimulus(1, 1'b1, 4'd0, 4'd0, 4'd0, 32'h41A0_0000);
    #1;
    checkOutput("t6_ready", 32'(reqReady), 32'h1);
    step();
    rst = 1'b1;
    checkOutput("t6_cur_valid", 32'(extInputValid), 32'h1);
    checkOutput("t6_cur_sel", 32'(extNodeSelect), 32'h01);
    checkOutput("t6_cur_ready", 32'(reqReady), 32'h0);
    step();
    checkOutput("t6_rst_valid", 32'(extInputValid), 32'h0);
    checkOutput("t6_rst_sel", 32'(extNodeSelect), 32'h0);
    checkOutput("t6_rst_id", 32'(extNeuronId), 32'h0);
    checkOutput("t6_rst_cur", extInputCurrent, 32'h0);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    checkOutput("t6_rst_count", 32'(injectCount), 32'h0);
    checkOutput("t6_rst_err", 32'(reqErr), 32'h0);
    checkOutput("t6_rst_ready", 32'(reqReady), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("t6_regrant", 32'(reqReady), 32'h1);
    step();
    applyStimulus(0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    applyStimulus(1, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    checkOutput("t6_cur_sel2", 32'(extNodeSelect), 32'h01);
    checkOutput("t6_cur_id2", 32'(extNeuronId), 32'h01);
    checkOutput("t6_cur_data2", extInputCurrent, 32'h4120_0000);
    step();
    checkOutput("t6_trg_id", 32'(extNeuronId), 32'h0E);
    step();
    checkOutput("t6_count", 32'(injectCount), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
